// File: rtl/gpio_pad_pkg.sv
// Shared constants for the GPIO pad controller: register map and debounce counter sizing.
package gpio_pad_pkg;

  // Register indices on the 3-bit bus address
  localparam logic [2:0] GPIO_DOUT     = 3'd0;
  localparam logic [2:0] GPIO_OE       = 3'd1;
  localparam logic [2:0] GPIO_OD       = 3'd2;
  localparam logic [2:0] GPIO_PULLEN   = 3'd3;
  localparam logic [2:0] GPIO_PULLUP   = 3'd4;
  localparam logic [2:0] GPIO_DIN      = 3'd5;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'd6;
  localparam logic [2:0] GPIO_IRQ_STAT = 3'd7;

  localparam int unsigned DEB_CYCLES_DFLT = 4;

  // Counter must hold 0..DEB_CYCLES-1; one spare bit of headroom keeps DEB_CYCLES=1 legal
  function automatic int unsigned deb_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  typedef logic [$clog2(DEB_CYCLES_DFLT + 1)-1:0] deb_cnt_t;

endpackage

// File: rtl/gpio_pad_in.sv
// One pad input: 2-flop synchroniser, stable-count debounce, both-edge pulse.
module gpio_pad_in
  import gpio_pad_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_d,
  output logic deb,
  output logic edge_pulse
);

  localparam int unsigned CNT_W = deb_cnt_w(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             s_q, s_d;
  logic             deb_q, deb_d;
  logic             deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next state: sync chain, counter runs only while the synced input disagrees with deb
  always_comb begin
    meta_d     = pad_d;
    s_d        = meta_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    deb_prev_d = deb_q;
    if (s_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = s_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset clears deb and its delayed copy together so no edge is seen
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= 1'b0;
      s_q        <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      meta_q     <= meta_d;
      s_q        <= s_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
    end
  end

  assign deb        = deb_q;
  assign edge_pulse = deb_q ^ deb_prev_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad bank controller: register file, registered pad drive mux, input debounce, level IRQ.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DFLT,
  parameter logic        SONOF_VAL  = 1'b1,
  parameter logic        CONOF_VAL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq,
  input  logic [WIDTH-1:0] pad_d,
  output logic [WIDTH-1:0] pad_a,
  output logic [WIDTH-1:0] pad_nen,
  output logic [WIDTH-1:0] pad_pen,
  output logic [WIDTH-1:0] pad_pu,
  output logic [WIDTH-1:0] pad_pd,
  output logic [WIDTH-1:0] pad_conof,
  output logic [WIDTH-1:0] pad_sonof
);

  logic [WIDTH-1:0] dout_q, dout_d, oe_q, oe_d, od_q, od_d;
  logic [WIDTH-1:0] pullen_q, pullen_d, pullup_q, pullup_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d, irq_stat_q, irq_stat_d;
  logic [WIDTH-1:0] rdata_q, rdata_d, rd_val;
  logic [WIDTH-1:0] pad_a_q, pad_a_d, pad_nen_q, pad_nen_d;
  logic [WIDTH-1:0] pad_pen_q, pad_pen_d, pad_pu_q, pad_pu_d, pad_pd_q, pad_pd_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] din_w, edge_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_in
    gpio_pad_in #(.DEB_CYCLES(DEB_CYCLES)) u_in (
      .clk        (clk),
      .rst        (rst),
      .pad_d      (pad_d[i]),
      .deb        (din_w[i]),
      .edge_pulse (edge_w[i])
    );
  end

  // Register writes, W1C status with set priority, read mux from pre-write state
  always_comb begin
    dout_d   = dout_q;
    oe_d     = oe_q;
    od_d     = od_q;
    pullen_d = pullen_q;
    pullup_d = pullup_q;
    irq_en_d = irq_en_q;
    irq_stat_d = irq_stat_q;
    if (wr_en) begin
      case (addr)
        GPIO_DOUT:     dout_d     = wdata;
        GPIO_OE:       oe_d       = wdata;
        GPIO_OD:       od_d       = wdata;
        GPIO_PULLEN:   pullen_d   = wdata;
        GPIO_PULLUP:   pullup_d   = wdata;
        GPIO_IRQ_EN:   irq_en_d   = wdata;
        GPIO_IRQ_STAT: irq_stat_d = irq_stat_q & ~wdata;
        default:       ;
      endcase
    end
    irq_stat_d = irq_stat_d | edge_w;

    case (addr)
      GPIO_DOUT:     rd_val = dout_q;
      GPIO_OE:       rd_val = oe_q;
      GPIO_OD:       rd_val = od_q;
      GPIO_PULLEN:   rd_val = pullen_q;
      GPIO_PULLUP:   rd_val = pullup_q;
      GPIO_DIN:      rd_val = din_w;
      GPIO_IRQ_EN:   rd_val = irq_en_q;
      default:       rd_val = irq_stat_q;
    endcase
    rdata_d = rd_en ? rd_val : rdata_q;

    // Open-drain bits never drive high: A forced low, driver on only when DOUT is 0
    pad_a_d   = dout_q & ~od_q;
    pad_nen_d = ~(oe_q & ~(od_q & dout_q));
    pad_pen_d = pullen_q;
    pad_pu_d  = pullen_q & pullup_q;
    pad_pd_d  = pullen_q & ~pullup_q;
    irq_d     = |(irq_stat_q & irq_en_q);
  end

  // All state and pad outputs registered; drivers come out of reset disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q     <= '0;
      oe_q       <= '0;
      od_q       <= '0;
      pullen_q   <= '0;
      pullup_q   <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      rdata_q    <= '0;
      pad_a_q    <= '0;
      pad_nen_q  <= '1;
      pad_pen_q  <= '0;
      pad_pu_q   <= '0;
      pad_pd_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      od_q       <= od_d;
      pullen_q   <= pullen_d;
      pullup_q   <= pullup_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      rdata_q    <= rdata_d;
      pad_a_q    <= pad_a_d;
      pad_nen_q  <= pad_nen_d;
      pad_pen_q  <= pad_pen_d;
      pad_pu_q   <= pad_pu_d;
      pad_pd_q   <= pad_pd_d;
      irq_q      <= irq_d;
    end
  end

  assign rdata     = rdata_q;
  assign irq       = irq_q;
  assign pad_a     = pad_a_q;
  assign pad_nen   = pad_nen_q;
  assign pad_pen   = pad_pen_q;
  assign pad_pu    = pad_pu_q;
  assign pad_pd    = pad_pd_q;
  assign pad_conof = {WIDTH{CONOF_VAL}};
  assign pad_sonof = {WIDTH{SONOF_VAL}};

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl (WIDTH=8, DEB_CYCLES=4).
module tb_gpio_pad_ctrl;
  import gpio_pad_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en;
  logic [2:0] addr;
  logic [7:0] wdata, rdata, pad_d;
  logic       irq;
  logic [7:0] pad_a, pad_nen, pad_pen, pad_pu, pad_pd, pad_conof, pad_sonof;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gpio_pad_ctrl #(.WIDTH(8), .DEB_CYCLES(4), .SONOF_VAL(1'b1), .CONOF_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .pad_d(pad_d), .pad_a(pad_a), .pad_nen(pad_nen),
    .pad_pen(pad_pen), .pad_pu(pad_pu), .pad_pd(pad_pd), .pad_conof(pad_conof),
    .pad_sonof(pad_sonof)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
    v = rdata;
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; pad_d = '0;
    tick(); tick();

    // 1. reset state
    chk("rst_nen", pad_nen, 32'hFF);
    chk("rst_a", pad_a, 32'h00);
    chk("rst_pen", pad_pen, 32'h00);
    chk("rst_irq", irq, 32'h0);
    chk("conof", pad_conof, 32'h00);
    chk("sonof", pad_sonof, 32'hFF);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      chk($sformatf("rst_rd%0d", i), v, 32'h00);
    end

    // 2. push-pull
    wr(GPIO_OE, 8'h0F);
    wr(GPIO_DOUT, 8'hA5);
    chk("pp_a_lat", pad_a, 32'h00);
    tick();
    chk("pp_a", pad_a, 32'hA5);
    chk("pp_nen", pad_nen, 32'hF0);
    rd(GPIO_DOUT, v);
    chk("pp_rd_dout", v, 32'hA5);

    // 3. open-drain on bit 0
    wr(GPIO_OD, 8'h01);
    wr(GPIO_OE, 8'h01);
    wr(GPIO_DOUT, 8'h00);
    tick();
    chk("od_nen_lo", pad_nen, 32'hFE);
    chk("od_a_lo", pad_a, 32'h00);
    wr(GPIO_DOUT, 8'h01);
    tick();
    chk("od_nen_hi", pad_nen, 32'hFF);
    chk("od_a_hi", pad_a, 32'h00);

    // 4. debounce: 3-cycle glitch is filtered
    pad_d = 8'h04;
    repeat (3) tick();
    pad_d = 8'h00;
    repeat (8) tick();
    rd(GPIO_DIN, v);
    chk("glitch_din", v, 32'h00);
    rd(GPIO_IRQ_STAT, v);
    chk("glitch_stat", v, 32'h00);

    // 4/5. sustained rise, exact latency, IRQ follow-up
    wr(GPIO_IRQ_EN, 8'h04);
    addr = GPIO_DIN; rd_en = 1'b1;
    pad_d = 8'h04;
    repeat (6) tick();
    chk("deb_not_yet", rdata, 32'h00);
    tick();
    chk("deb_rise", rdata, 32'h04);
    chk("irq_not_yet", irq, 32'h0);
    tick();
    chk("irq_set", irq, 32'h1);
    rd_en = 1'b0;
    rd(GPIO_IRQ_STAT, v);
    chk("stat_set", v, 32'h04);

    // W1C clears status, irq drops one cycle later
    wr(GPIO_IRQ_STAT, 8'h04);
    tick();
    chk("irq_clr", irq, 32'h0);
    rd(GPIO_IRQ_STAT, v);
    chk("stat_clr", v, 32'h00);

    // clear coincident with a falling edge: set wins
    pad_d = 8'h00;
    repeat (6) tick();
    wr(GPIO_IRQ_STAT, 8'h04);
    rd(GPIO_IRQ_STAT, v);
    chk("set_wins", v, 32'h04);
    chk("set_wins_irq", irq, 32'h1);
    rd(GPIO_DIN, v);
    chk("deb_fall", v, 32'h00);

    // rd and wr same cycle: read returns old value
    wr_en = 1'b1; rd_en = 1'b1; addr = GPIO_IRQ_EN; wdata = 8'h0C;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdwr_old", rdata, 32'h04);
    rd(GPIO_IRQ_EN, v);
    chk("rdwr_new", v, 32'h0C);

    // writes to DIN ignored
    wr(GPIO_DIN, 8'hFF);
    rd(GPIO_DIN, v);
    chk("din_ro", v, 32'h00);

    // 6. pulls
    wr(GPIO_PULLEN, 8'h03);
    wr(GPIO_PULLUP, 8'h01);
    tick();
    chk("pull_pen", pad_pen, 32'h03);
    chk("pull_pu", pad_pu, 32'h01);
    chk("pull_pd", pad_pd, 32'h02);

    // reset mid-debounce on bit 4
    pad_d = 8'h10;
    repeat (3) tick();
    rst = 1'b1;
    pad_d = 8'h00;
    tick();
    chk("mr_nen", pad_nen, 32'hFF);
    chk("mr_a", pad_a, 32'h00);
    chk("mr_pen", pad_pen, 32'h00);
    chk("mr_pu", pad_pu, 32'h00);
    chk("mr_pd", pad_pd, 32'h00);
    chk("mr_irq", irq, 32'h0);
    chk("mr_rdata", rdata, 32'h00);
    rst = 1'b0;
    repeat (10) tick();
    chk("mr_irq_after", irq, 32'h0);
    rd(GPIO_DIN, v);
    chk("mr_din", v, 32'h00);
    rd(GPIO_IRQ_STAT, v);
    chk("mr_stat", v, 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
